// File: rtl/rv_iopmp_cfg_loader.sv
// rtl/rv_iopmp_cfg_loader.sv - table-driven IOPMP config register programmer (optional readback verify: IOPMP_CFG_LOADER_VERIFY_EN)
package rv_iopmp_cfg_loader_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module rv_iopmp_cfg_loader #(
  parameter type         reg_req_t      = rv_iopmp_cfg_loader_pkg::reg_req_t,
  parameter type         reg_rsp_t      = rv_iopmp_cfg_loader_pkg::reg_rsp_t,
  parameter int unsigned MAX_RECORDS    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned NW = $clog2(MAX_RECORDS + 1),
  localparam int unsigned IW = $clog2(MAX_RECORDS),
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [NW-1:0] num_records_i,
  output logic [IW-1:0] tbl_idx_o,
  input  logic [31:0]   tbl_addr_i,
  input  logic [31:0]   tbl_data_i,
  input  logic [3:0]    tbl_wstrb_i,
  output reg_req_t      cfg_reg_req_o,
  input  reg_rsp_t      cfg_reg_rsp_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [IW-1:0] err_idx_o
);

  localparam logic [1:0] ERR_BUS      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
`ifdef IOPMP_CFG_LOADER_VERIFY_EN
  localparam logic [1:0] ERR_READBACK = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_WRITE,
`ifdef IOPMP_CFG_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] num_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   cap_addr_q;
  logic [31:0]   cap_data_q;
  logic [3:0]    cap_strb_q;
  logic [1:0]    err_code_q;
  logic [IW-1:0] err_idx_q;
  logic [TW-1:0] tmo_q;

  logic          accept_start;
  logic          do_capture;
  logic          do_advance;
  logic          set_err;
  logic [1:0]    err_code_d;
  logic          req_valid;
  logic          last_rec;
  logic          tmo_last;
  logic [NW-1:0] num_clamped;

  // Oversized requests are limited to the table depth so the index can never wrap.
  assign num_clamped = (num_records_i > NW'(MAX_RECORDS)) ? NW'(MAX_RECORDS) : num_records_i;
  assign last_rec    = (NW'(idx_q) == (num_q - NW'(1)));
  assign tmo_last    = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  assign tbl_idx_o   = idx_q;
  assign err_code_o  = err_code_q;
  assign err_idx_o   = err_idx_q;

`ifdef IOPMP_CFG_LOADER_VERIFY_EN
  logic [31:0] strb_mask;
  assign strb_mask = {{8{cap_strb_q[3]}}, {8{cap_strb_q[2]}}, {8{cap_strb_q[1]}}, {8{cap_strb_q[0]}}};
`else
  logic [31:0] unused_rdata;
  assign unused_rdata = cfg_reg_rsp_i.rdata;
`endif

  // State register; reset drops any outstanding request immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, request drive and status decode.
  always_comb begin
    state_d       = state_q;
    cfg_reg_req_o = '0;
    accept_start  = 1'b0;
    do_capture    = 1'b0;
    do_advance    = 1'b0;
    set_err       = 1'b0;
    err_code_d    = 2'd0;
    req_valid     = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        done_o = (state_q == S_DONE);
        err_o  = (state_q == S_ERR);
        if (start_i) begin
          accept_start = 1'b1;
          state_d      = (num_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        busy_o  = 1'b1;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy_o     = 1'b1;
        do_capture = 1'b1;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        busy_o              = 1'b1;
        req_valid           = 1'b1;
        cfg_reg_req_o.valid = 1'b1;
        cfg_reg_req_o.write = 1'b1;
        cfg_reg_req_o.addr  = cap_addr_q;
        cfg_reg_req_o.wdata = cap_data_q;
        cfg_reg_req_o.wstrb = cap_strb_q;
        if (cfg_reg_rsp_i.ready) begin
          if (cfg_reg_rsp_i.error) begin
            set_err    = 1'b1;
            err_code_d = ERR_BUS;
            state_d    = S_ERR;
          end else begin
`ifdef IOPMP_CFG_LOADER_VERIFY_EN
            state_d = S_VERIFY;
`else
            do_advance = 1'b1;
            state_d    = last_rec ? S_DONE : S_FETCH;
`endif
          end
        end else if (tmo_last) begin
          set_err    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end
      end
`ifdef IOPMP_CFG_LOADER_VERIFY_EN
      S_VERIFY: begin
        busy_o              = 1'b1;
        req_valid           = 1'b1;
        cfg_reg_req_o.valid = 1'b1;
        cfg_reg_req_o.addr  = cap_addr_q;
        if (cfg_reg_rsp_i.ready) begin
          if (cfg_reg_rsp_i.error) begin
            set_err    = 1'b1;
            err_code_d = ERR_BUS;
            state_d    = S_ERR;
          end else if (((cfg_reg_rsp_i.rdata ^ cap_data_q) & strb_mask) != 32'd0) begin
            set_err    = 1'b1;
            err_code_d = ERR_READBACK;
            state_d    = S_ERR;
          end else begin
            do_advance = 1'b1;
            state_d    = last_rec ? S_DONE : S_FETCH;
          end
        end else if (tmo_last) begin
          set_err    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Run bookkeeping: record count, index, captured record, error status and stall timer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      num_q      <= '0;
      idx_q      <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      cap_strb_q <= '0;
      err_code_q <= '0;
      err_idx_q  <= '0;
      tmo_q      <= '0;
    end else begin
      if (accept_start) begin
        num_q      <= num_clamped;
        idx_q      <= '0;
        err_code_q <= '0;
        err_idx_q  <= '0;
      end else if (do_advance && !last_rec) begin
        idx_q <= idx_q + IW'(1);
      end
      if (do_capture) begin
        cap_addr_q <= tbl_addr_i;
        cap_data_q <= tbl_data_i;
        cap_strb_q <= tbl_wstrb_i;
      end
      if (set_err) begin
        err_code_q <= err_code_d;
        err_idx_q  <= idx_q;
      end
      // Counts consecutive stalled request cycles; any non-stall cycle rearms it.
      if (req_valid && !cfg_reg_rsp_i.ready) tmo_q <= tmo_q + TW'(1);
      else                                   tmo_q <= '0;
    end
  end

endmodule
